// File: rtl/cbb_bin2onehot_pipe.sv
// cbb_bin2onehot_pipe: multi-channel registered binary-to-onehot decoder
// with valid/ready handshake, 2-entry skid buffer, occupancy mask, counter.
//
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   in_valid/ready   input handshake; in_ready is registered (!skid_full)
//   in_bin           CH_NUM codes, channel k at [k*BIN_WIDTH +: BIN_WIDTH]
//   in_mode          00 onehot, 01 thermometer, 10 reversed, 11 reserved
//   out_valid/ready  output handshake
//   out_data         CH_NUM decoded words, channel k at [k*OW +: OW]
//   out_err          beat carried the reserved mode
//   occ_clr          sync clear of occ_mask
//   occ_mask         sticky OR of all channels of handshaken beats
//   xfer_cnt         saturating count of output handshakes
module cbb_bin2onehot_pipe #(
  parameter int BIN_WIDTH = 3,
  parameter int CH_NUM    = 2,
  parameter int CNT_WIDTH = 16,
  localparam int ONEHOT_WIDTH = 1 << BIN_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CH_NUM*BIN_WIDTH-1:0]    in_bin,
  input  logic [1:0]                     in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CH_NUM*ONEHOT_WIDTH-1:0] out_data,
  output logic                           out_err,
  input  logic                           occ_clr,
  output logic [ONEHOT_WIDTH-1:0]        occ_mask,
  output logic [CNT_WIDTH-1:0]           xfer_cnt
);

  localparam int DW = CH_NUM * ONEHOT_WIDTH;

  logic          w_md_oh;
  logic          w_md_th;
  logic          w_md_rv;
  logic [DW-1:0] w_dec_data;
  logic          w_dec_err;

  assign w_md_oh   = (in_mode == 2'b00);
  assign w_md_th   = (in_mode == 2'b01);
  assign w_md_rv   = (in_mode == 2'b10);
  assign w_dec_err = (in_mode == 2'b11);

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [BIN_WIDTH-1:0] w_code;
    assign w_code = in_bin[k*BIN_WIDTH +: BIN_WIDTH];
    for (genvar j = 0; j < ONEHOT_WIDTH; j++) begin : g_bit
      localparam logic [BIN_WIDTH-1:0] LJ =
        BIN_WIDTH'(j);
      localparam logic [BIN_WIDTH-1:0] LR =
        BIN_WIDTH'(ONEHOT_WIDTH - 1 - j);
      logic w_bit;
      always_comb begin
        w_bit = 1'b0;
        unique case (1'b1)
          w_md_oh: w_bit = (w_code == LJ);
          // bit j set for every j <= code
          w_md_th: w_bit = (w_code >= LJ);
          w_md_rv: w_bit = (w_code == LR);
          default: w_bit = 1'b0;
        endcase
      end
      assign w_dec_data[k*ONEHOT_WIDTH+j] = w_bit;
    end
  end

  logic          r_main_vld;
  logic [DW-1:0] r_main_data;
  logic          r_main_err;
  logic          r_skid_vld;
  logic [DW-1:0] r_skid_data;
  logic          r_skid_err;
  logic          r_in_ready;

  logic w_acc;
  logic w_hs;
  logic w_main_free;
  logic w_skid_nxt;

  assign w_acc       = in_valid & r_in_ready;
  assign w_hs        = r_main_vld & out_ready;
  assign w_main_free = ~r_main_vld | out_ready;
  // skid only fills while main is held; it empties whenever main frees
  assign w_skid_nxt  = w_main_free ? 1'b0 : (r_skid_vld | w_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld  <= 1'b0;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_skid_vld <= w_skid_nxt;
      r_in_ready <= ~w_skid_nxt;
      if (w_main_free) begin
        if (r_skid_vld) begin
          r_main_vld  <= 1'b1;
          r_main_data <= r_skid_data;
          r_main_err  <= r_skid_err;
        end else if (w_acc) begin
          r_main_vld  <= 1'b1;
          r_main_data <= w_dec_data;
          r_main_err  <= w_dec_err;
        end else begin
          r_main_vld  <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid_data <= w_dec_data;
        r_skid_err  <= w_dec_err;
      end
    end
  end

  logic [ONEHOT_WIDTH-1:0] w_or;

  always_comb begin
    w_or = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      w_or = w_or | r_main_data[k*ONEHOT_WIDTH +: ONEHOT_WIDTH];
    end
    if (r_main_err) begin
      w_or = '0;
    end
  end

  logic [ONEHOT_WIDTH-1:0] r_occ;
  logic [CNT_WIDTH-1:0]    r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
      r_cnt <= '0;
    end else begin
      // clear drops old contents; a same-cycle beat still lands
      if (occ_clr) begin
        r_occ <= w_hs ? w_or : '0;
      end else if (w_hs) begin
        r_occ <= r_occ | w_or;
      end
      if (w_hs && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_vld;
  assign out_data  = r_main_data;
  assign out_err   = r_main_err;
  assign occ_mask  = r_occ;
  assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_cbb_bin2onehot_pipe.sv
// tb_cbb_bin2onehot_pipe: directed + random bench with a queue-based
// reference model of the decoder pipeline.
module tb_cbb_bin2onehot_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_bin;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
  logic        occ_clr;
  logic [7:0]  occ_mask;
  logic [15:0] xfer_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [15:0] out_data2;
  logic        out_err2;
  logic [7:0]  occ_mask2;
  logic [3:0]  xfer_cnt4;

  always #5 clk = ~clk;

  cbb_bin2onehot_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err),
    .occ_clr(occ_clr), .occ_mask(occ_mask),
    .xfer_cnt(xfer_cnt)
  );

  cbb_bin2onehot_pipe #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_bin(in_bin), .in_mode(in_mode),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_err(out_err2),
    .occ_clr(occ_clr), .occ_mask(occ_mask2),
    .xfer_cnt(xfer_cnt4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the mode rules.
  function automatic logic [16:0] mdec(input logic [1:0] m,
                                       input logic [5:0] bin);
    logic [15:0] d;
    int b;
    int v;
    d = '0;
    for (int k = 0; k < 2; k++) begin
      b = int'(bin[k*3 +: 3]);
      case (m)
        2'd0:    v = 1 << b;
        2'd1:    v = (1 << (b + 1)) - 1;
        2'd2:    v = 1 << (7 - b);
        default: v = 0;
      endcase
      d[k*8 +: 8] = v[7:0];
    end
    return {(m == 2'd3), d};
  endfunction

  // Model: FIFO of at most two held beats, front is what is presented.
  logic [16:0] m_q[$];
  logic [7:0]  m_occ = '0;
  int          m_cnt = 0;
  int          mn;
  bit          mhs;
  bit          macc;
  logic [7:0]  morv;
  logic [16:0] mf;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_occ = '0;
      m_cnt = 0;
    end else begin
      mn   = m_q.size();
      mhs  = (mn > 0) && out_ready;
      macc = in_valid && (mn < 2);
      morv = '0;
      if (mhs) begin
        mf = m_q.pop_front();
        if (!mf[16]) morv = mf[15:8] | mf[7:0];
        m_cnt++;
      end
      if (occ_clr) m_occ = morv;
      else         m_occ = m_occ | morv;
      if (macc) m_q.push_back(mdec(in_mode, in_bin));
    end
  end

  bit          cap_en = 1'b0;
  logic [15:0] got[$];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready", in_ready, m_q.size() < 2);
      chk("out_valid", out_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("out_data", out_data, m_q[0][15:0]);
        chk("out_err", out_err, m_q[0][16]);
      end
      chk("occ_mask", occ_mask, m_occ);
      chk("xfer_cnt", xfer_cnt,
          (m_cnt > 65535) ? 65535 : m_cnt);
      chk("xfer_cnt4", xfer_cnt4,
          (m_cnt > 15) ? 15 : m_cnt);
      if (cap_en && out_valid && out_ready) got.push_back(out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [5:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_bin   = b;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck 0 after %0d", t);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] exp_seq [4];
  bit hold;

  initial begin
    exp_seq[0] = 16'h0201;
    exp_seq[1] = 16'h0804;
    exp_seq[2] = 16'h0703;
    exp_seq[3] = 16'h0802;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    occ_clr   = 1'b0;
    in_mode   = 2'd0;
    in_bin    = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_occ", occ_mask, 0);
    chk("rst_cnt", xfer_cnt, 0);
    rst_n = 1'b1;
    tick();

    send(2'd0, {3'd5, 3'd2});
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 16'h2004);
    chk("t1_err", out_err, 0);
    tick();
    chk("t1_cnt", xfer_cnt, 1);
    chk("t1_occ", occ_mask, 8'h24);

    send(2'd1, {3'd7, 3'd0});
    chk("thermo_data", out_data, 16'hFF01);
    tick();
    send(2'd2, {3'd0, 3'd7});
    chk("rev_data", out_data, 16'h8001);
    tick();
    send(2'd3, {3'd4, 3'd1});
    chk("rsv_data", out_data, 16'h0000);
    chk("rsv_err", out_err, 1);
    tick();
    chk("rsv_occ", occ_mask, 8'hFF);

    occ_clr = 1'b1;
    tick();
    occ_clr = 1'b0;
    chk("clr_alone", occ_mask, 8'h00);
    send(2'd0, {3'd5, 3'd2});
    tick();
    chk("occ_acc", occ_mask, 8'h24);
    send(2'd0, {3'd1, 3'd1});
    occ_clr = 1'b1;
    tick();
    occ_clr = 1'b0;
    chk("clr_with_hs", occ_mask, 8'h02);
    occ_clr = 1'b1;
    tick();
    occ_clr = 1'b0;
    chk("clr_alone2", occ_mask, 8'h00);

    out_ready = 1'b0;
    cap_en    = 1'b1;
    send(2'd0, {3'd1, 3'd0});
    send(2'd0, {3'd3, 3'd2});
    chk("bp_ready_drop", in_ready, 0);
    chk("bp_hold_a", out_data, 16'h0201);
    tick();
    chk("bp_stable_a", out_data, 16'h0201);
    chk("bp_ready_low", in_ready, 0);
    out_ready = 1'b1;
    send(2'd1, {3'd2, 3'd1});
    send(2'd2, {3'd4, 3'd6});
    repeat (4) tick();
    cap_en = 1'b0;
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("bp_order", got[i], exp_seq[i]);
    end
    chk("bp_cnt", xfer_cnt, 10);

    out_ready = 1'b0;
    send(2'd0, {3'd6, 3'd6});
    send(2'd0, {3'd7, 3'd7});
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_occ", occ_mask, 0);
    chk("arst_cnt", xfer_cnt, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    send(2'd1, {3'd3, 3'd5});
    chk("post_rst_data", out_data, 16'h0F3F);
    chk("post_rst_err", out_err, 0);
    tick();
    chk("post_rst_cnt", xfer_cnt, 1);

    hold = 1'b0;
    repeat (3000) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_mode  = 2'($urandom);
        in_bin   = 6'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      occ_clr   = ($urandom_range(0, 19) == 0);
      hold      = in_valid && !in_ready;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    occ_clr   = 1'b0;
    repeat (5) tick();
    chk("sat_cnt4", xfer_cnt4, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cbb_bin2onehot_pipe.md
Name: cbb_bin2onehot_pipe

Overview:
Multi-channel, registered binary-to-onehot decoder with a valid/ready handshake and a 2-entry skid buffer, so it sustains full throughput under backpressure. A per-transaction mode selects onehot, thermometer or reversed-onehot decode. A sticky occupancy mask and a saturating transfer counter support bucket tracking in the sort datapath. Sits between the key-extraction stage and the bucket/bitmap logic.

Parameters:
BIN_WIDTH, 3, bits per binary code per channel
CH_NUM, 2, number of parallel channels
ONEHOT_WIDTH, 1<<BIN_WIDTH, decoded width per channel (derived, not overridden)
CNT_WIDTH, 16, width of transfer counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid&&in_ready
in_bin  input  CH_NUM*BIN_WIDTH  channel k at bits [k*BIN_WIDTH +: BIN_WIDTH]
in_mode  input  2  00 onehot, 01 thermometer, 10 reversed onehot, 11 reserved
out_valid  output  1  output beat valid
out_ready  input  1  downstream accept
out_data  output  CH_NUM*ONEHOT_WIDTH  channel k at bits [k*ONEHOT_WIDTH +: ONEHOT_WIDTH]
out_err  output  1  beat carried reserved mode; travels with out_data
occ_clr  input  1  synchronous clear of occ_mask
occ_mask  output  ONEHOT_WIDTH  sticky OR of all channels of all accepted output beats
xfer_cnt  output  CNT_WIDTH  count of output handshakes, saturating at all-ones

Behaviour:
- Reset: in_ready=1 (registered), out_valid=0, out_data=0, out_err=0, occ_mask=0, xfer_cnt=0, skid empty. Reset mid-operation discards all held beats, with no partial outputs.
- Decode per channel, b = code value: mode 00 -> bit b set only; 01 -> bits 0..b set (b=0 gives 1, b=max gives all-ones); 10 -> bit ONEHOT_WIDTH-1-b only; 11 -> all zeros and out_err=1. out_err=0 for modes 00/01/10. Mode applies to all channels of the beat.
- Decode happens before the registers. Latency is 1 cycle: a beat accepted at edge N is presented at edge N with out_valid=1, visible in cycle N+1.
- Storage: main output register and skid register, each holding data+err. All beats are kept in order.
- Skid buffer operation:
  - If the main register is empty, or it is valid with out_ready=1, an accepted beat loads the main register (from skid first if skid is full).
  - If the main register is held (out_valid&&!out_ready) and an accepted beat arrives, that beat goes to the skid register.
  - in_ready is registered and equals !skid_full. It is never combinationally dependent on out_ready.
  - When skid is full and the main register drains, the skid beat moves to main the same edge, in_ready returns to 1 the next cycle, and no beat is lost or duplicated.
- Output stability: while out_valid&&!out_ready, out_data and out_err must not change.
- Throughput: one beat per cycle when out_ready is held at 1.
- Occupancy mask:
  - On each output handshake, occ_mask |= OR over channels of out_data.
  - Error beats contribute zeros.
  - occ_clr alone sets occ_mask to 0.
  - occ_clr together with a handshake sets occ_mask to the current beat's OR only (the clear applies to old contents).
- xfer_cnt increments on each output handshake, holds at 2^CNT_WIDTH-1, and is cleared only by reset.
- in_valid without in_ready: the beat is not taken and the source must hold it. X on in_bin while in_valid=0 must not propagate.

Test Plan:
- BIN_WIDTH=3, CH_NUM=2, mode 00, in_bin={3'd5,3'd2}, out_ready=1 -> next cycle out_valid=1, out_data={8'h20,8'h04}, out_err=0, xfer_cnt=1, occ_mask=8'h24.
- Mode 01, in_bin={3'd7,3'd0} -> out_data={8'hFF,8'h01}. Mode 10, in_bin={3'd0,3'd7} -> out_data={8'h80,8'h01}. Mode 11 -> out_data=0, out_err=1, occ_mask unchanged.
- Backpressure: stream beats A,B,C,D back-to-back with out_ready=0 for 3 cycles, then 1 -> in_ready drops after 2 beats are held. Output order is A,B,C,D with no loss or duplicate. out_data stays stable while stalled. xfer_cnt=4.
- occ_clr: accumulate 8'h24, then assert occ_clr in the same cycle as a handshake of bin {1,1} -> occ_mask=8'h02. occ_clr alone -> 8'h00.
- Reset asserted while skid is full and out_valid=1 -> out_valid=0, in_ready=1, occ_mask=0 and xfer_cnt=0 immediately (asynchronous). The first beat after release decodes correctly.
- CNT_WIDTH=4, 20 handshakes -> xfer_cnt saturates at 4'hF.
